prog_loader: RTL and testbench

//  Program-load sequencer that sits directly upstream of prog_mux and drives its we/sel/waddr/wdata.

---
 rtl/prog_loader.sv | 129 ++++++++++++
 tb/tb_prog_loader.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Program-load sequencer: parses header/address/length/data packets from a
// valid/ready word stream and emits one registered prog_mux write per data word.
module prog_loader #(
    parameter int CORES       = 4,
    parameter int LOG_CORES   = 2,
    parameter int PC_WIDTH    = 4,
    parameter int INSTR_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [INSTR_WIDTH-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   we,
    output logic [LOG_CORES-1:0]   sel,
    output logic [PC_WIDTH-1:0]    waddr,
    output logic [INSTR_WIDTH-1:0] wdata,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    typedef enum logic [1:0] {
        S_HDR,
        S_ADDR,
        S_LEN,
        S_DATA
    } state_t;

    localparam logic [INSTR_WIDTH-1:0] CORES_W = INSTR_WIDTH'(CORES);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_xfer;
    logic                   w_data_xfer;
    logic                   w_last;

    logic [LOG_CORES-1:0]   r_core;
    logic [PC_WIDTH-1:0]    r_addr;
    logic [PC_WIDTH-1:0]    r_remaining;
    logic                   r_err;
    logic                   r_we;
    logic [LOG_CORES-1:0]   r_sel;
    logic [PC_WIDTH-1:0]    r_waddr;
    logic [INSTR_WIDTH-1:0] r_wdata;
    logic                   r_busy;
    logic                   r_done;

    assign in_ready = en;
    assign w_xfer   = in_valid & en;

    // NOTE: every signal gets a default before any branch, so no path can leave it unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_data_xfer = 1'b0;
        w_last      = 1'b0;
        if (!en) begin
            w_state_nxt = S_HDR;
        end else if (w_xfer) begin
            case (r_state)
                S_HDR:  w_state_nxt = S_ADDR;
                S_ADDR: w_state_nxt = S_LEN;
                S_LEN:  w_state_nxt = S_DATA;
                S_DATA: begin
                    w_data_xfer = 1'b1;
                    w_last      = (r_remaining == '0);
                    if (w_last) w_state_nxt = S_HDR;
                end
                default: w_state_nxt = S_HDR;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_HDR;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_core      <= '0;
            r_addr      <= '0;
            r_remaining <= '0;
            r_err       <= 1'b0;
            r_we        <= 1'b0;
            r_sel       <= '0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_we   <= w_data_xfer & ~r_err;
            r_done <= w_last;
            r_busy <= (w_state_nxt != S_HDR);
            if (w_xfer) begin
                case (r_state)
                    S_HDR: begin
                        r_core <= in_data[LOG_CORES-1:0];
                        r_err  <= (in_data >= CORES_W);
                    end
                    S_ADDR: r_addr      <= in_data[PC_WIDTH-1:0];
                    S_LEN:  r_remaining <= in_data[PC_WIDTH-1:0];
                    S_DATA: begin
                        r_addr      <= r_addr + 1'b1;
                        r_remaining <= r_remaining - 1'b1;
                        // Rejected packets leave the prog_mux bus holding the last real write.
                        if (!r_err) begin
                            r_sel   <= r_core;
                            r_waddr <= r_addr;
                            r_wdata <= in_data;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign we    = r_we;
    assign sel   = r_sel;
    assign waddr = r_waddr;
    assign wdata = r_wdata;
    assign busy  = r_busy;
    assign done  = r_done;
    assign err   = r_err;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader (CORES=3): writes are logged at the falling
// edge and compared with hand-built expectations after each scenario.
module tb_prog_loader;

    localparam int CORES       = 3;
    localparam int LOG_CORES   = 2;
    localparam int PC_WIDTH    = 4;
    localparam int INSTR_WIDTH = 8;

    typedef struct packed {
        logic [LOG_CORES-1:0]   sel;
        logic [PC_WIDTH-1:0]    waddr;
        logic [INSTR_WIDTH-1:0] wdata;
        logic                   done;
    } wr_t;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   en;
    logic [INSTR_WIDTH-1:0] in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic                   we;
    logic [LOG_CORES-1:0]   sel;
    logic [PC_WIDTH-1:0]    waddr;
    logic [INSTR_WIDTH-1:0] wdata;
    logic                   busy;
    logic                   done;
    logic                   err;

    int  n_checks = 0;
    int  n_fail   = 0;
    int  done_cnt = 0;
    wr_t log_q[$];
    wr_t exp_q[$];

    prog_loader #(
        .CORES      (CORES),
        .LOG_CORES  (LOG_CORES),
        .PC_WIDTH   (PC_WIDTH),
        .INSTR_WIDTH(INSTR_WIDTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .we      (we),
        .sel     (sel),
        .waddr   (waddr),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        wr_t w_entry;
        if (we) begin
            w_entry = '{sel: sel, waddr: waddr, wdata: wdata, done: done};
            log_q.push_back(w_entry);
        end
        if (done) done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; the word transfers on the next edge.
    task automatic put(input logic [INSTR_WIDTH-1:0] d);
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_wr(input int s, input int a, input int d, input logic dn);
        wr_t e;
        e.sel   = LOG_CORES'(s);
        e.waddr = PC_WIDTH'(a);
        e.wdata = INSTR_WIDTH'(d);
        e.done  = dn;
        exp_q.push_back(e);
    endtask

    task automatic compare_log(input string tag);
        check({tag, "_nwr"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            check({tag, "_sel"},   32'(log_q[i].sel),   32'(exp_q[i].sel));
            check({tag, "_waddr"}, 32'(log_q[i].waddr), 32'(exp_q[i].waddr));
            check({tag, "_wdata"}, 32'(log_q[i].wdata), 32'(exp_q[i].wdata));
            check({tag, "_done"},  32'(log_q[i].done),  32'(exp_q[i].done));
        end
        log_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"},    32'(we),    0);
        check({tag, "_sel"},   32'(sel),   0);
        check({tag, "_waddr"}, 32'(waddr), 0);
        check({tag, "_wdata"}, 32'(wdata), 0);
        check({tag, "_busy"},  32'(busy),  0);
        check({tag, "_done"},  32'(done),  0);
        check({tag, "_err"},   32'(err),   0);
    endtask

    initial begin
        logic [INSTR_WIDTH-1:0] t4_words [6];
        int                     done_snap;

        t4_words = '{8'h01, 8'h05, 8'h02, 8'hA1, 8'hA2, 8'hA3};

        rst_n    = 1'b0;
        en       = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        #23;
        check_reset_outputs("reset");
        check("reset_in_ready", 32'(in_ready), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b1;
        #1;
        check("in_ready_en", 32'(in_ready), 1);

        // T1: back-to-back packet to core 1.
        put(8'h01);
        check("t1_busy_hdr", 32'(busy), 1);
        put(8'h05);
        put(8'h02);
        put(8'hA1);
        put(8'hA2);
        put(8'hA3);
        check("t1_done_last", 32'(done), 1);
        check("t1_busy_end", 32'(busy), 0);
        idle(1);
        check("t1_we_idle", 32'(we), 0);
        check("t1_done_idle", 32'(done), 0);
        check("t1_hold_waddr", 32'(waddr), 7);
        check("t1_hold_wdata", 32'(wdata), 32'hA3);
        idle(1);
        expect_wr(1, 5, 8'hA1, 1'b0);
        expect_wr(1, 6, 8'hA2, 1'b0);
        expect_wr(1, 7, 8'hA3, 1'b1);
        compare_log("t1");

        // T2: address wrap 14,15,0,1.
        put(8'h00);
        put(8'h0E);
        put(8'h03);
        put(8'hD0);
        put(8'hD1);
        put(8'hD2);
        put(8'hD3);
        idle(2);
        expect_wr(0, 14, 8'hD0, 1'b0);
        expect_wr(0, 15, 8'hD1, 1'b0);
        expect_wr(0, 0,  8'hD2, 1'b0);
        expect_wr(0, 1,  8'hD3, 1'b1);
        compare_log("t2");

        // T3: invalid core 3, then valid core 2 clears err.
        done_snap = done_cnt;
        put(8'h03);
        check("t3_err_set", 32'(err), 1);
        put(8'h02);
        put(8'h01);
        put(8'h55);
        put(8'h66);
        check("t3_done_err", 32'(done), 1);
        check("t3_we_err", 32'(we), 0);
        idle(2);
        check("t3_err_held", 32'(err), 1);
        check("t3_done_cnt", 32'(done_cnt - done_snap), 1);
        compare_log("t3a");
        put(8'h02);
        check("t3_err_clear", 32'(err), 0);
        put(8'h00);
        put(8'h00);
        put(8'h77);
        idle(2);
        expect_wr(2, 0, 8'h77, 1'b1);
        compare_log("t3b");

        // Full-word range check: low bits name core 1 but the word is out of range.
        put(8'h41);
        check("hdr_fullword_err", 32'(err), 1);
        put(8'h03);
        put(8'h00);
        put(8'h88);
        idle(2);
        compare_log("t3c");

        // T4: T1 stream with two idle cycles after every word.
        for (int i = 0; i < 6; i++) begin
            put(t4_words[i]);
            if (i == 0) check("t4_err_clear", 32'(err), 0);
            check("t4_we_lat", 32'(we), (i >= 3) ? 1 : 0);
            for (int g = 0; g < 2; g++) begin
                idle(1);
                check("t4_we_gap", 32'(we), 0);
            end
        end
        expect_wr(1, 5, 8'hA1, 1'b0);
        expect_wr(1, 6, 8'hA2, 1'b0);
        expect_wr(1, 7, 8'hA3, 1'b1);
        compare_log("t4");

        // T5: abort after first of three data words.
        done_snap = done_cnt;
        put(8'h02);
        put(8'h08);
        put(8'h02);
        put(8'hB1);
        check("t5_we_first", 32'(we), 1);
        en       = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hB2;
        #1;
        check("t5_in_ready_low", 32'(in_ready), 0);
        idle(1);
        check("t5_we_abort", 32'(we), 0);
        check("t5_busy_abort", 32'(busy), 0);
        idle(2);
        check("t5_done_none", 32'(done_cnt - done_snap), 0);
        in_valid = 1'b0;
        en       = 1'b1;
        expect_wr(2, 8, 8'hB1, 1'b0);
        compare_log("t5a");
        put(8'h01);
        put(8'h03);
        put(8'h00);
        put(8'hC1);
        idle(2);
        expect_wr(1, 3, 8'hC1, 1'b1);
        compare_log("t5b");

        // T6: asynchronous reset in the middle of DATA.
        put(8'h00);
        put(8'h09);
        put(8'h03);
        put(8'hE1);
        put(8'hE2);
        check("t6_we_before", 32'(we), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        idle(2);
        #2;
        rst_n = 1'b1;
        idle(1);
        expect_wr(0, 9, 8'hE1, 1'b0);
        compare_log("t6a");
        put(8'h01);
        put(8'h01);
        put(8'h01);
        put(8'hF1);
        put(8'hF2);
        idle(2);
        expect_wr(1, 1, 8'hF1, 1'b0);
        expect_wr(1, 2, 8'hF2, 1'b1);
        compare_log("t6b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
